// File: rtl/mix_array_stream_reader_pkg.sv
// mix_array_pkg: shared widths, depth, read latency and FSM states for the mix-array reader
package mix_array_pkg;
  localparam int MIX_DATA_W = 32;
  localparam int MIX_ADDR_W = 5;
  localparam int MIX_DEPTH  = 32;
  localparam int MIX_RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mix_array_stream_reader_if.sv
// mix_array_stream_reader_if: RAM port-0 and output stream bundle; m_last exists only with MIX_READER_LAST_EN
interface mix_array_stream_reader_if import mix_array_pkg::*; #(
  parameter int DW = MIX_DATA_W,
  parameter int AW = MIX_ADDR_W
);
  logic [AW-1:0] address0;
  logic          ce0;
  logic          we0;
  logic [DW-1:0] d0;
  logic [DW-1:0] q0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef MIX_READER_LAST_EN
  logic          m_last;
  modport master (output address0, ce0, we0, d0, m_data, m_valid, m_last, input q0, m_ready);
  modport slave  (input address0, ce0, we0, d0, m_data, m_valid, m_last, output q0, m_ready);
`else
  modport master (output address0, ce0, we0, d0, m_data, m_valid, input q0, m_ready);
  modport slave  (input address0, ce0, we0, d0, m_data, m_valid, output q0, m_ready);
`endif
endinterface

// File: rtl/mix_array_stream_reader_skid_fifo.sv
// mix_array_skid_fifo: 2-entry valid/ready buffer that passes a push straight through when empty
module mix_array_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   level
);
  logic [W-1:0] h, t;
  logic pop, wr_h, wr_t;
  assign valid = level != 2'd0 || push;
  assign dout  = level != 2'd0 ? h : push ? din : '0;
  assign pop   = valid && ready;
  assign wr_h  = push && ((level == 2'd0 && !pop) || (level == 2'd1 && pop));
  assign wr_t  = push && ((level == 2'd1 && !pop) || (level == 2'd2 && pop));
  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= '0;
      h     <= '0;
      t     <= '0;
    end else begin
      level <= level + 2'(push) - 2'(pop);
      if (pop && level == 2'd2) h <= t;
      else if (wr_h) h <= din;
      if (wr_t) t <= din;
    end
  end
endmodule

// File: rtl/mix_array_stream_reader.sv
// mix_array_stream_reader: streams length words from a 1-cycle-latency RAM starting at base
// Optional m_last output is enabled by defining MIX_READER_LAST_EN.
module mix_array_stream_reader import mix_array_pkg::*; #(
  parameter int DataWidth    = MIX_DATA_W,
  parameter int AddressWidth = MIX_ADDR_W,
  parameter int AddressRange = MIX_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AddressWidth-1:0] base,
  input  logic [AddressWidth:0] length,
  output logic                  busy,
  output logic                  done,
  mix_array_stream_reader_if.master bus
);
  localparam int CW = AddressWidth + 1;
  state_t state, nxt;
  logic [AddressWidth-1:0] base_r;
  logic [CW-1:0] len_r, issued, accepted, acc_n;
  logic [MIX_RD_LAT-1:0] rd_pipe;
  logic [1:0] level;
  logic issue, hs, fin;
  // credit: buffered words plus reads still in the RAM pipe never exceed the buffer depth
  assign issue = state == RUN && issued != len_r && (3'(level) + 3'($countones(rd_pipe))) < 3'd2;
  assign hs    = bus.m_valid && bus.m_ready;
  assign acc_n = accepted + CW'(hs);
  assign fin   = acc_n == len_r;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign bus.ce0      = issue;
  assign bus.address0 = issue ? base_r + issued[AddressWidth-1:0] : '0;
  assign bus.we0      = 1'b0;
  assign bus.d0       = '0;
`ifdef MIX_READER_LAST_EN
  assign bus.m_last = bus.m_valid && accepted == len_r - CW'(1);
`endif
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = length == '0 ? DONE : RUN;
    else if (state == DONE) nxt = IDLE;
    else if (state != IDLE) nxt = fin ? DONE : issued == len_r ? DRAIN : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      base_r   <= '0;
      len_r    <= '0;
      issued   <= '0;
      accepted <= '0;
      rd_pipe  <= '0;
    end else begin
      state   <= nxt;
      rd_pipe <= MIX_RD_LAT'({rd_pipe, issue});
      if (state == IDLE && start) begin
        base_r   <= base;
        len_r    <= length > CW'(AddressRange) ? CW'(AddressRange) : length;
        issued   <= '0;
        accepted <= '0;
      end else begin
        issued   <= issued + CW'(issue);
        accepted <= acc_n;
      end
    end
  end
  mix_array_skid_fifo #(.W(DataWidth)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pipe[MIX_RD_LAT-1]),
    .din   (bus.q0),
    .ready (bus.m_ready),
    .dout  (bus.m_data),
    .valid (bus.m_valid),
    .level (level)
  );
endmodule

// File: tb/tb_mix_array_stream_reader.sv
// tb_mix_array_stream_reader: directed scenarios against a RAM model and stream monitor
module tb_mix_array_stream_reader;
  logic clk = 0, reset = 0, start = 0, busy, done;
  logic [4:0] base = 0;
  logic [5:0] length = 0;
  logic [31:0] mem [32];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int s_cyc, first_valid, last_hs, done_cyc, done_cnt, outstanding, credit_err, stall_err, valid_seen;
  logic prev_v, prev_r;
  logic [31:0] prev_d;
  logic [31:0] got [$];
  logic [4:0] addrs [$];
  logic last_q [$];
  mix_array_stream_reader_if #(.DW(32), .AW(5)) bus ();
  mix_array_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length),
    .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.ce0) bus.q0 <= mem[bus.address0];
  always @(negedge clk) begin
    if (!reset) begin
      outstanding = 0;
      prev_v = 0;
    end else begin
      if (prev_v && !prev_r && !(bus.m_valid && bus.m_data == prev_d)) stall_err++;
      if (bus.ce0) begin
        if (outstanding >= 2) credit_err++;
        addrs.push_back(bus.address0);
      end
      if (bus.m_valid) begin
        valid_seen++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        last_hs = cyc;
`ifdef MIX_READER_LAST_EN
        last_q.push_back(bus.m_last);
`endif
      end
      outstanding += int'(bus.ce0) - int'(bus.m_valid && bus.m_ready);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_v = bus.m_valid;
      prev_r = bus.m_ready;
      prev_d = bus.m_data;
    end
  end
  task clear_log;
    got.delete(); addrs.delete(); last_q.delete();
    first_valid = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
    credit_err = 0; stall_err = 0; valid_seen = 0;
  endtask
  task run_job(input logic [4:0] b, input logic [5:0] l);
    int n = 0;
    @(posedge clk); #1;
    start = 1; base = b; length = l; s_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (done_cnt == 0) begin n_bad++; $display("FAIL done_timeout base=%0d len=%0d", b, l); end
    repeat (2) @(posedge clk);
    #1;
  endtask
  task test_reset;
    reset = 0; bus.m_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done, bus.ce0, bus.m_valid} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, bus.ce0, bus.m_valid}); end
    n_cmp++; if (bus.address0 !== 5'd0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", bus.address0); end
    n_cmp++; if (bus.m_data !== 32'd0) begin n_bad++; $display("FAIL reset_data got %0h want 0", bus.m_data); end
    n_cmp++; if ({bus.we0, bus.d0} !== 33'd0) begin n_bad++; $display("FAIL tied_we_d got %0h want 0", {bus.we0, bus.d0}); end
    #1 reset = 1;
  endtask
  task test_full;
    clear_log();
    run_job(5'd0, 6'd32);
    n_cmp++; if (got.size() != 32) begin n_bad++; $display("FAIL full_count got %0d want 32", got.size()); end
    for (int i = 0; i < got.size() && i < 32; i++) begin
      n_cmp++; if (got[i] !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL full_word%0d got %0h want %0h", i, got[i], 32'h100 + 32'(i)); end
    end
    n_cmp++; if (first_valid - s_cyc != 2) begin n_bad++; $display("FAIL full_latency got %0d want 2", first_valid - s_cyc); end
    n_cmp++; if (last_hs - first_valid != 31) begin n_bad++; $display("FAIL full_throughput got %0d want 31", last_hs - first_valid); end
    n_cmp++; if (done_cyc - last_hs != 1) begin n_bad++; $display("FAIL full_done_delay got %0d want 1", done_cyc - last_hs); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_after got %b want 0", busy); end
  endtask
  task test_wrap;
    logic [4:0] ea [4];
    logic [31:0] ed [4];
    ea = '{5'd30, 5'd31, 5'd0, 5'd1};
    ed = '{32'h11E, 32'h11F, 32'h100, 32'h101};
    clear_log();
    run_job(5'd30, 6'd4);
    n_cmp++; if (addrs.size() != 4 || got.size() != 4) begin n_bad++; $display("FAIL wrap_count got %0d/%0d want 4/4", addrs.size(), got.size()); end
    for (int i = 0; i < 4 && i < addrs.size() && i < got.size(); i++) begin
      n_cmp++; if (addrs[i] !== ea[i]) begin n_bad++; $display("FAIL wrap_addr%0d got %0d want %0d", i, addrs[i], ea[i]); end
      n_cmp++; if (got[i] !== ed[i]) begin n_bad++; $display("FAIL wrap_data%0d got %0h want %0h", i, got[i], ed[i]); end
    end
  endtask
  task test_backpressure;
    bit on;
    clear_log();
    on = 1;
    fork
      begin run_job(5'd3, 6'd8); on = 0; end
      begin
        int k = 0;
        while (on) begin
          @(posedge clk); #1;
          bus.m_ready = (k % 4 == 0) || (k % 4 == 3);
          k++;
        end
      end
    join
    bus.m_ready = 1;
    n_cmp++; if (got.size() != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_cmp++; if (got[i] !== 32'h103 + 32'(i)) begin n_bad++; $display("FAIL bp_word%0d got %0h want %0h", i, got[i], 32'h103 + 32'(i)); end
    end
    n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL bp_stable got %0d want 0", stall_err); end
    n_cmp++; if (credit_err != 0) begin n_bad++; $display("FAIL bp_credit got %0d want 0", credit_err); end
    n_cmp++; if (addrs.size() != 8) begin n_bad++; $display("FAIL bp_reads got %0d want 8", addrs.size()); end
  endtask
  task test_zero;
    clear_log();
    run_job(5'd7, 6'd0);
    n_cmp++; if (addrs.size() != 0) begin n_bad++; $display("FAIL zero_reads got %0d want 0", addrs.size()); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc - s_cyc != 1) begin n_bad++; $display("FAIL zero_done_delay got %0d want 1", done_cyc - s_cyc); end
    n_cmp++; if (valid_seen != 0) begin n_bad++; $display("FAIL zero_valid got %0d want 0", valid_seen); end
  endtask
  task test_reset_mid;
    int n = 0;
    clear_log();
    @(posedge clk); #1;
    start = 1; base = 5'd0; length = 6'd8;
    @(posedge clk); #1;
    start = 0;
    while (got.size() < 3 && n < 100) begin @(negedge clk); #1; n++; end
    n_cmp++; if (got.size() < 3) begin n_bad++; $display("FAIL mid_timeout got %0d want 3", got.size()); end
    reset = 0;
    @(negedge clk);
    n_cmp++; if ({busy, done, bus.ce0, bus.m_valid} !== 4'b0) begin n_bad++; $display("FAIL mid_reset_ctrl got %b want 0000", {busy, done, bus.ce0, bus.m_valid}); end
    n_cmp++; if ({bus.address0, bus.m_data} !== 37'd0) begin n_bad++; $display("FAIL mid_reset_bus got %0h want 0", {bus.address0, bus.m_data}); end
    #1 reset = 1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
    clear_log();
    run_job(5'd5, 6'd2);
    n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL mid_new_count got %0d want 2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      n_cmp++; if (got[i] !== 32'h105 + 32'(i)) begin n_bad++; $display("FAIL mid_new_word%0d got %0h want %0h", i, got[i], 32'h105 + 32'(i)); end
    end
  endtask
  task test_start_busy;
    clear_log();
    fork
      run_job(5'd0, 6'd6);
      begin
        repeat (3) @(posedge clk);
        #1 start = 1; base = 5'd20; length = 6'd2;
        @(posedge clk);
        #1 start = 0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (got.size() != 6 || addrs.size() != 6) begin n_bad++; $display("FAIL busy_count got %0d/%0d want 6/6", got.size(), addrs.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_cmp++; if (got[i] !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL busy_word%0d got %0h want %0h", i, got[i], 32'h100 + 32'(i)); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
  endtask
`ifdef MIX_READER_LAST_EN
  task test_last;
    logic el [3];
    el = '{1'b0, 1'b0, 1'b1};
    clear_log();
    run_job(5'd9, 6'd3);
    n_cmp++; if (last_q.size() != 3) begin n_bad++; $display("FAIL last_count got %0d want 3", last_q.size()); end
    for (int i = 0; i < last_q.size() && i < 3; i++) begin
      n_cmp++; if (last_q[i] !== el[i]) begin n_bad++; $display("FAIL last_flag%0d got %b want %b", i, last_q[i], el[i]); end
    end
    n_cmp++; if (bus.m_last !== 1'b0) begin n_bad++; $display("FAIL last_idle got %b want 0", bus.m_last); end
  endtask
`endif
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    clear_log();
    test_reset();
    test_full();
    test_wrap();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_start_busy();
`ifdef MIX_READER_LAST_EN
    test_last();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mix_array_stream_reader.md
Name: mix_array_stream_reader

Overview:
- Initiator-side read engine for the HLS-style dual-port mix-array RAMs (32 words x 32 bits, 1-cycle registered read).
- Drives the RAM's port-0 address/ce/we/d signals and captures q0 with the correct 1-cycle latency.
- Emits the fetched words on a valid/ready output stream with full backpressure support.
- Sits between a node-mix array and downstream compute or DMA logic that consumes array contents in order.

Parameters:
- DataWidth, 32, RAM word width.
- AddressWidth, 5, RAM address width.
- AddressRange, 32, number of RAM words; a job must not exceed this length.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle job request; sampled only in IDLE.
- base  in  AddressWidth  first word address of the job.
- length  in  AddressWidth+1  words to read, 0..AddressRange.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- address0  out  AddressWidth  RAM port-0 address.
- ce0  out  1  RAM port-0 enable.
- we0  out  1  RAM port-0 write enable; tied to 0.
- d0  out  DataWidth  RAM port-0 write data; tied to 0.
- q0  in  DataWidth  RAM port-0 read data; valid the cycle after ce0.
- m_data  out  DataWidth  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word when m_valid and m_ready are both high.

Behaviour:
- Reset (reset==0 at a clk edge) forces the following, regardless of state:
  - state=IDLE, all counters cleared, buffer emptied.
  - busy=0, done=0, ce0=0, address0=0, m_valid=0, m_data=0.
  - Reset mid-job abandons the job; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with length!=0: latch base and length, go to RUN, busy=1.
  - start with length==0: go to DONE directly; no RAM access, busy=1 for that one cycle.
  - start while not in IDLE is ignored.
- RUN, issuing reads:
  - Issue a read (ce0=1, address0=(base+issued) mod 2^AddressWidth) when issued<length and (buffer occupancy + reads in flight) < 2.
  - The address wraps at 2^AddressWidth.
  - When issued==length, go to DRAIN.
- RUN, read capture:
  - q0 is captured into a 2-entry FIFO exactly one cycle after each ce0=1.
  - The head of the FIFO drives m_data/m_valid.
  - The credit rule above guarantees no overflow.
  - With m_ready held high, sustained throughput is 1 word/cycle. Latency is start to first m_valid = 2 cycles.
- DRAIN:
  - No new reads are issued.
  - When accepted==length, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
  - A start in the DONE cycle is ignored.
- Stream rules:
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_valid may be asserted in the same cycle as a FIFO push plus pop.
- A simultaneous push and pop when the FIFO is full is legal and keeps occupancy at 2.
- Counters are AddressWidth+1 bits; length==AddressRange reads every word once, starting at base and wrapping.

Optional Feature:
- Macro: MIX_READER_LAST_EN.
- When defined:
  - Adds output port m_last (1 bit), high on the final word of the job (accepted==length-1) while m_valid=1.
  - m_last=0 after reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mix_array_pkg holds:
  - Defaults MIX_DATA_W=32, MIX_ADDR_W=5, MIX_DEPTH=32.
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Read-latency constant MIX_RD_LAT=1.
- One natural sub-module: mix_array_skid_fifo, a 2-entry valid/ready buffer with a push side fed from q0 and a pop side driving the m_* signals.

Test Plan:
- RAM preloaded with mem[i]=i+0x100; base=0, length=32, m_ready=1 -> m_data=0x100..0x11F on 32 consecutive cycles; first m_valid 2 cycles after start; done exactly 1 cycle after the last handshake.
- base=30, length=4 -> addresses 30,31,0,1 issued; output 0x11E,0x11F,0x100,0x101.
- length=8 with m_ready toggling 1,0,0,1 repeating -> 8 words delivered in order, no loss or duplication; m_data stable while stalled; ce0 never issued when occupancy+in-flight reads==2.
- length=0 start -> no ce0 pulses; done pulses once, 1 cycle after start; m_valid stays 0.
- reset=0 asserted mid-job after 3 words -> next cycle all outputs at reset values and no done pulse; a new job with base=5, length=2 then returns 0x105,0x106.
- start pulsed while busy -> ignored, current job completes unchanged. With MIX_READER_LAST_EN defined, length=3 -> m_last high only on the third word.
